// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller and its event FIFO.
package keypad_pkg;

    localparam int unsigned CODE_W = 4;

    typedef logic [CODE_W-1:0] key_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_REPEAT,
        ST_RELEASE
    } kp_state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small power-of-two event FIFO with registered empty/full/head outputs.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = CODE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = head_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan pacing, per-tick debounce/auto-repeat FSM, and buffered key-event output.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned REPEAT_DLY  = 500,
    parameter int unsigned REPEAT_RATE = 100,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic      Clk,
    input  logic      Reset,
    input  logic      Scan_Valid,
    input  key_code_t Scan_Code,
    output logic      Scan_En,
    output logic      Key_Valid,
    output key_code_t Key_Code,
    input  logic      Key_Ready,
    output logic      Overflow,
    input  logic      Clr_Ovf
);

    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned TICK_W  = cnt_width(TICK_DIV - 1);
    localparam int unsigned DEB_W   = cnt_width(DEBOUNCE);
    localparam int unsigned REP_W   = cnt_width(REP_MAX);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              scan_en_q, scan_en_d;
    kp_state_t         state_q, state_d;
    key_code_t         code_q, code_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [REP_W-1:0]  rep_q, rep_d, rep_inc;
    logic              ovf_q, ovf_d;
    logic              same;
    logic              push_c;
    logic              pop_c;
    logic              fifo_full, fifo_empty;
    key_code_t         fifo_head;

    // Free-running tick divider; Scan_En is high while the count sits at TICK_DIV-1.
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_W'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TICK_W'(1);
        scan_en_d  = (tick_cnt_d == TICK_W'(TICK_DIV - 1));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tick_cnt_q <= '0;
            scan_en_q  <= 1'b0;
            state_q    <= ST_IDLE;
            code_q     <= '0;
            cnt_q      <= '0;
            rep_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_en_q  <= scan_en_d;
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            ovf_q      <= ovf_d;
        end
    end

    // Debounce / repeat FSM; it only moves on the edge that closes a Scan_En cycle.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        push_c  = 1'b0;
        same    = Scan_Valid && (Scan_Code == code_q);
        cnt_inc = (cnt_q == DEB_W'(DEBOUNCE)) ? cnt_q : cnt_q + DEB_W'(1);
        rep_inc = (rep_q == REP_W'(REP_MAX)) ? rep_q : rep_q + REP_W'(1);

        if (scan_en_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Scan_Valid) begin
                        code_d = Scan_Code;
                        if (DEBOUNCE == 1) begin
                            push_c  = 1'b1;
                            state_d = ST_PRESSED;
                            rep_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = DEB_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (same) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_W'(DEBOUNCE)) begin
                            push_c  = 1'b1;
                            state_d = ST_PRESSED;
                            rep_d   = '0;
                        end
                    end else if (Scan_Valid) begin
                        code_d = Scan_Code;
                        cnt_d  = DEB_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (same) begin
                        if (REPEAT_DLY != 0) begin
                            rep_d = rep_inc;
                            if (rep_inc == REP_W'(REPEAT_DLY)) begin
                                push_c  = 1'b1;
                                state_d = ST_REPEAT;
                                rep_d   = '0;
                            end
                        end
                    end else begin
                        state_d = ST_RELEASE;
                        cnt_d   = Scan_Valid ? DEB_W'(0) : DEB_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (same) begin
                        rep_d = rep_inc;
                        if (rep_inc == REP_W'(REPEAT_RATE)) begin
                            push_c = 1'b1;
                            rep_d  = '0;
                        end
                    end else begin
                        state_d = ST_RELEASE;
                        cnt_d   = Scan_Valid ? DEB_W'(0) : DEB_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!Scan_Valid) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_W'(DEBOUNCE)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sticky overflow: a dropped event sets it even when a clear arrives on the same edge.
    always_comb begin
        pop_c = Key_Ready && !fifo_empty;
        ovf_d = ovf_q;
        if (push_c && fifo_full && !pop_c) begin
            ovf_d = 1'b1;
        end else if (Clr_Ovf) begin
            ovf_d = 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset),
        .push      (push_c),
        .push_data (Scan_Code),
        .pop       (pop_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign Scan_En   = scan_en_q;
    assign Key_Valid = !fifo_empty;
    assign Key_Code  = fifo_head;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed stimulus for keypad_scan_ctrl, checked every cycle against a
// tick-level behavioural model (run-length debounce, hold-time repeat schedule, queue FIFO).
module tb_keypad_scan_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned RDLY     = 5;
    localparam int unsigned RRATE    = 2;
    localparam int unsigned DEPTH    = 4;

    logic       clk;
    logic       rst_n;
    logic       sv;
    logic [3:0] sc;
    logic       kr;
    logic       clr;
    logic       scan_en;
    logic       key_valid;
    logic [3:0] key_code;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int dut_pops = 0;

    keypad_scan_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE    (DEB),
        .REPEAT_DLY  (RDLY),
        .REPEAT_RATE (RRATE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Scan_Valid (sv),
        .Scan_Code  (sc),
        .Scan_En    (scan_en),
        .Key_Valid  (key_valid),
        .Key_Code   (key_code),
        .Key_Ready  (kr),
        .Overflow   (overflow),
        .Clr_Ovf    (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    localparam int P_FREE = 0;
    localparam int P_HELD = 1;
    localparam int P_REL  = 2;

    int         phase;
    int         run_len;
    logic [3:0] run_code;
    logic [3:0] held_code;
    int         held_t;
    int         zero_run;
    int         mc;
    logic       m_ovf;
    logic [3:0] mq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        mc       = 0;
        phase    = P_FREE;
        run_len  = 0;
        run_code = '0;
        held_code = '0;
        held_t   = 0;
        zero_run = 0;
    endfunction

    // One scan tick: a press is a run of DEB identical valid samples; repeats fall at
    // hold times RDLY, RDLY+RRATE, ...; release needs DEB consecutive empty samples.
    function automatic void model_tick(input logic v, input logic [3:0] c,
                                       output logic ev, output logic [3:0] ec);
        ev = 1'b0;
        ec = '0;
        case (phase)
            P_FREE: begin
                if (!v) run_len = 0;
                else if (run_len > 0 && c == run_code) run_len++;
                else begin
                    run_code = c;
                    run_len  = 1;
                end
                if (run_len >= DEB) begin
                    ev        = 1'b1;
                    ec        = run_code;
                    phase     = P_HELD;
                    held_code = run_code;
                    held_t    = 0;
                end
            end
            P_HELD: begin
                if (v && c == held_code) begin
                    held_t++;
                    if (RDLY != 0 && held_t >= RDLY && ((held_t - RDLY) % RRATE) == 0) begin
                        ev = 1'b1;
                        ec = held_code;
                    end
                end else begin
                    phase    = P_REL;
                    zero_run = v ? 0 : 1;
                end
            end
            default: begin
                if (v) zero_run = 0;
                else zero_run++;
                if (zero_run >= DEB) begin
                    phase   = P_FREE;
                    run_len = 0;
                end
            end
        endcase
    endfunction

    // One clock: advance the model across the edge, then compare all outputs.
    task automatic step();
        logic       tick;
        logic       ev;
        logic       pop;
        logic [3:0] ec;
        if (key_valid && kr) dut_pops++;
        @(posedge clk);
        tick = ((mc % TICK_DIV) == TICK_DIV - 1);
        mc++;
        ev = 1'b0;
        ec = '0;
        if (tick) model_tick(sv, sc, ev, ec);
        pop = (mq.size() != 0) && kr;
        if (pop) void'(mq.pop_front());
        if (ev && mq.size() >= DEPTH) m_ovf = 1'b1;
        else begin
            if (ev) mq.push_back(ec);
            if (clr) m_ovf = 1'b0;
        end
        #1;
        check_eq("scan_en", 32'(scan_en), 32'((mc % TICK_DIV) == TICK_DIV - 1));
        check_eq("key_valid", 32'(key_valid), 32'(mq.size() != 0));
        check_eq("key_code", 32'(key_code), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic hold(input logic v, input logic [3:0] c, input int nticks);
        sv = v;
        sc = c;
        repeat (nticks * TICK_DIV) step();
    endtask

    initial begin
        int p0;
        int first;
        logic       rv;
        logic [3:0] rc;
        int         rl;
        logic [3:0] codes[3];

        rst_n = 1'b0;
        sv    = 1'b0;
        sc    = '0;
        kr    = 1'b0;
        clr   = 1'b0;
        model_reset();
        #22;
        check_eq("rst_scan_en", 32'(scan_en), 32'd0);
        check_eq("rst_key_valid", 32'(key_valid), 32'd0);
        check_eq("rst_key_code", 32'(key_code), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: single press of 7, popped once
        kr = 1'b1;
        p0 = dut_pops;
        hold(1'b1, 4'h7, 3);
        hold(1'b0, 4'h0, 4);
        check_eq("t1_events", 32'(dut_pops - p0), 32'd1);

        // 2: bounce 1,0,1,1,1 gives one event
        p0 = dut_pops;
        hold(1'b1, 4'h2, 1);
        hold(1'b0, 4'h2, 1);
        hold(1'b1, 4'h2, 3);
        hold(1'b0, 4'h0, 4);
        check_eq("t2_events", 32'(dut_pops - p0), 32'd1);

        // 3: long hold with auto-repeat
        p0 = dut_pops;
        hold(1'b1, 4'hA, 13);
        hold(1'b0, 4'h0, 6);
        check_eq("t3_events", 32'(dut_pops - p0), 32'd4);

        // 4: overflow with consumer stalled
        kr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            hold(1'b1, 4'(k), 3);
            hold(1'b0, 4'h0, 3);
        end
        check_eq("t4_ovf_set", 32'(overflow), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
        p0 = dut_pops;
        kr = 1'b1;
        repeat (8) step();
        check_eq("t4_pops", 32'(dut_pops - p0), 32'd4);

        // 5: key switch without release
        p0 = dut_pops;
        hold(1'b1, 4'h3, 4);
        hold(1'b1, 4'h5, 5);
        hold(1'b0, 4'h0, 3);
        hold(1'b1, 4'h5, 3);
        hold(1'b0, 4'h0, 4);
        check_eq("t5_events", 32'(dut_pops - p0), 32'd2);

        // 6: reset while debouncing with queued events
        kr = 1'b0;
        hold(1'b1, 4'h8, 3);
        hold(1'b0, 4'h0, 3);
        hold(1'b1, 4'h9, 3);
        hold(1'b0, 4'h0, 3);
        hold(1'b1, 4'hC, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_key_valid", 32'(key_valid), 32'd0);
        check_eq("t6_scan_en", 32'(scan_en), 32'd0);
        check_eq("t6_overflow", 32'(overflow), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Scan_En is high in the TICK_DIV-th cycle, i.e. after TICK_DIV-1 edges
        first = -1;
        for (int n = 1; n <= 2 * TICK_DIV && first < 0; n++) begin
            step();
            if (scan_en) first = n;
        end
        check_eq("t6_first_tick", 32'(first), 32'(TICK_DIV - 1));
        sv = 1'b0;
        repeat (4 * TICK_DIV) step();

        // Random phase
        codes[0] = 4'h1;
        codes[1] = 4'h6;
        codes[2] = 4'hE;
        for (int it = 0; it < 150; it++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = codes[$urandom_range(0, 2)];
            rl = int'($urandom_range(1, 8));
            sv = rv;
            sc = rc;
            repeat (rl * TICK_DIV) begin
                kr  = ($urandom_range(0, 2) != 0);
                clr = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
